// File: rtl/strobe_pkg.sv
// strobe_pkg: shared FSM state type and averaging depth for strobe_period_meter
// Optional averaging build: define STROBE_PERIOD_AVG_EN.
package strobe_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, OVERFLOW} spm_state_t;
  localparam int SPM_AVG_LOG2 = 2;
endpackage

// File: rtl/spm_avg.sv
// spm_avg: averages every 2**SPM_AVG_LOG2 period samples into a registered mean
// Ports: clk, rst (async active-low), clr_i (drop partial sum), sample_i/valid_i
// (one measurement), mean_o/valid_o (registered mean and its one-cycle pulse).
module spm_avg
  import strobe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] sample_i,
  input  logic             valid_i,
  output logic [CNT_W-1:0] mean_o,
  output logic             valid_o
);
  logic [CNT_W+SPM_AVG_LOG2-1:0] sum_q, sum_d;
  logic [SPM_AVG_LOG2-1:0]       sub_q;
  logic [CNT_W-1:0]              mean_q;
  logic                          vld_q;
  assign sum_d = sum_q + {{SPM_AVG_LOG2{1'b0}}, sample_i};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sum_q  <= '0;
      sub_q  <= '0;
      mean_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      sum_q <= '0;
      sub_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= valid_i && (&sub_q);
      if (valid_i) begin
        sub_q <= sub_q + 1'b1;
        sum_q <= (&sub_q) ? '0 : sum_d;
        if (&sub_q) mean_q <= sum_d[SPM_AVG_LOG2 +: CNT_W];
      end
    end
  assign mean_o  = mean_q;
  assign valid_o = vld_q;
endmodule

// File: rtl/strobe_period_meter.sv
// strobe_period_meter: measures clk-cycle spacing between single-cycle strobes
// Ports: clk, rst (async active-low), en (low forces IDLE), strobe;
// period (last measured period, held), period_valid (pulse on update),
// timeout (pulse on entering OVERFLOW), lost (level while in OVERFLOW).
// Define STROBE_PERIOD_AVG_EN to publish the mean of every 4 measurements.
module strobe_period_meter
  import strobe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             strobe,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             lost
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  spm_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             to_q, lost_q, meas_v, sat;
  // A strobe in MEASURE wins over saturation, so sat requires no strobe.
  assign meas_v = en && state_q == MEASURE && strobe;
  assign sat    = en && state_q == MEASURE && !strobe && cnt_q == CNT_MAX;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      to_q <= sat;
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        lost_q  <= 1'b0;
      end else
        case (state_q)
          IDLE: state_q <= ARMED;
          ARMED:
            if (strobe) begin
              cnt_q   <= CNT_W'(1);
              state_q <= MEASURE;
            end
          MEASURE:
            if (strobe) cnt_q <= CNT_W'(1);
            else if (sat) begin
              state_q <= OVERFLOW;
              lost_q  <= 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
          OVERFLOW:
            if (strobe) begin
              cnt_q   <= CNT_W'(1);
              state_q <= MEASURE;
              lost_q  <= 1'b0;
            end
          default: state_q <= IDLE;
        endcase
    end
`ifdef STROBE_PERIOD_AVG_EN
  spm_avg #(.CNT_W(CNT_W)) u_avg (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (!en || sat),
    .sample_i(cnt_q),
    .valid_i (meas_v),
    .mean_o  (period),
    .valid_o (period_valid)
  );
`else
  logic [CNT_W-1:0] period_q;
  logic             pv_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      pv_q <= meas_v;
      if (meas_v) period_q <= cnt_q;
    end
  assign period       = period_q;
  assign period_valid = pv_q;
`endif
  assign timeout = to_q;
  assign lost    = lost_q;
endmodule

// File: tb/tb_strobe_period_meter.sv
// tb_strobe_period_meter: random and directed strobes on 16-bit and 4-bit meters vs a time-based model
module tb_strobe_period_meter;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, strobe = 1'b0;
  logic [15:0] p16;
  logic [3:0]  p4;
  logic        v16, t16, l16, v4, t4, l4;
  int n_chk = 0, n_fail = 0, t = 0;
  bit act[2], has_ref[2], el[2], epv[2], eto[2];
  int last_t[2], asum[2], acnt[2];
  int ep[2];
  int mx[2] = '{65535, 15};
  always #5 clk = ~clk;
  strobe_period_meter #(.CNT_W(16)) u_d16 (
    .clk(clk), .rst(rst), .en(en), .strobe(strobe),
    .period(p16), .period_valid(v16), .timeout(t16), .lost(l16)
  );
  strobe_period_meter #(.CNT_W(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .strobe(strobe),
    .period(p4), .period_valid(v4), .timeout(t4), .lost(l4)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask
  task automatic check_all();
    chk("d16.period", int'(p16), ep[0]);
    chk("d16.valid", int'(v16), int'(epv[0]));
    chk("d16.timeout", int'(t16), int'(eto[0]));
    chk("d16.lost", int'(l16), int'(el[0]));
    chk("d4.period", int'(p4), ep[1]);
    chk("d4.valid", int'(v4), int'(epv[1]));
    chk("d4.timeout", int'(t4), int'(eto[1]));
    chk("d4.lost", int'(l4), int'(el[1]));
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; has_ref[i] = 0; el[i] = 0; epv[i] = 0; eto[i] = 0;
      ep[i] = 0; asum[i] = 0; acnt[i] = 0; last_t[i] = 0;
    end
  endtask
  // Model: a period is the elapsed time since the reference strobe, valid
  // while that time has not exceeded the counter range.
  task automatic model_step(input bit e, input bit s);
    for (int i = 0; i < 2; i++) begin
      epv[i] = 0;
      eto[i] = 0;
      if (!e) begin
        act[i] = 0; has_ref[i] = 0; el[i] = 0; asum[i] = 0; acnt[i] = 0;
      end else if (!act[i]) act[i] = 1;
      else if (s) begin
        if (has_ref[i] && !el[i]) begin
`ifdef STROBE_PERIOD_AVG_EN
          asum[i] += t - last_t[i];
          acnt[i]++;
          if (acnt[i] == 4) begin
            ep[i] = asum[i] / 4; epv[i] = 1; asum[i] = 0; acnt[i] = 0;
          end
`else
          ep[i] = t - last_t[i];
          epv[i] = 1;
`endif
        end
        has_ref[i] = 1; last_t[i] = t; el[i] = 0;
      end else if (has_ref[i] && !el[i] && t - last_t[i] == mx[i]) begin
        eto[i] = 1; el[i] = 1; asum[i] = 0; acnt[i] = 0;
      end
    end
  endtask
  task automatic cyc(input bit e, input bit s);
    @(negedge clk);
    check_all();
    en = e;
    strobe = s;
    model_step(e, s);
    t++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    check_all();
    en = 0;
    strobe = 0;
    rst = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1;
    repeat (3) cyc(1, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1);
      repeat (19) cyc(1, 0);
    end
    repeat (3) cyc(1, 1);
    repeat (5) cyc(1, 0);
    repeat (40) cyc(1, 0);
    cyc(1, 1);
    repeat (6) cyc(1, 0);
    cyc(1, 1);
    repeat (14) cyc(1, 0);
    cyc(1, 1);
    repeat (15) cyc(1, 0);
    cyc(1, 1);
    repeat (9) cyc(1, 0);
    cyc(1, 1);
    repeat (7) cyc(1, 0);
    for (int k = 0; k < 6; k++) cyc(0, 1'($urandom_range(0, 1)));
    cyc(1, 1);
    cyc(1, 1);
    repeat (11) cyc(1, 0);
    cyc(1, 1);
    for (int k = 20; k < 24; k++) begin
      repeat (k - 1) cyc(1, 0);
      cyc(1, 1);
    end
    repeat (5) cyc(1, 0);
    do_reset();
    repeat (2) cyc(1, 0);
    cyc(1, 1);
    repeat (12) cyc(1, 0);
    cyc(1, 1);
    for (int k = 0; k < 3000; k++) begin
      int dens;
      dens = (k / 500) % 3 == 0 ? 3 : ((k / 500) % 3 == 1 ? 12 : 25);
      cyc($urandom_range(0, 79) != 0, $urandom_range(0, dens) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    @(negedge clk);
    check_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/strobe_period_meter.md
# strobe_period_meter

Measures the spacing, in `clk` cycles, between successive single-cycle strobes, such as those produced by the strobe generator fed from a `frqdivmod` divider. It publishes each measured period with a one-cycle valid pulse and flags loss of input when no strobe arrives within the counter range. It sits directly downstream of the strobe generator and feeds frequency-display and sequencing logic.

## Interface
- `CNT_W`, 16: width of the cycle counter and of the `period` output.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  measurement enable; low forces IDLE.
- `strobe`  in  1  single-cycle strobe, synchronous to `clk`.
- `period`  out  CNT_W  last measured period in cycles; holds between updates.
- `period_valid`  out  1  one-cycle pulse when `period` updates.
- `timeout`  out  1  one-cycle pulse on entering OVERFLOW.
- `lost`  out  1  level; high while in OVERFLOW.

## Operation
- States: IDLE, ARMED, MEASURE, OVERFLOW.
- IDLE: `cnt`=0. If `en`=1, go to ARMED next cycle.
- ARMED: wait for the first strobe. On `strobe`, set `cnt`:=1 and go to MEASURE. No period is output.
- MEASURE: `cnt` increments each cycle without a strobe.
  - On `strobe`: `period`:=`cnt`, `period_valid`:=1, `cnt`:=1, stay in MEASURE.
  - Strobes at cycles t0 and t1 give `period` = t1−t0. Back-to-back strobes give 1.
- Saturation: if `cnt` = 2^CNT_W−1 and there is no strobe, go to OVERFLOW, pulse `timeout`, set `lost`=1, and freeze `cnt`.
- Simultaneous strobe and saturation: the strobe wins. Report `period` = 2^CNT_W−1 and stay in MEASURE.
- OVERFLOW: on `strobe`, set `cnt`:=1, go to MEASURE and clear `lost`. No period is output for that strobe.
- `en`=0 in any state: go to IDLE next cycle, clear `cnt` and `lost`, and suppress pulses. `period` keeps its last value.
- Counter arithmetic is unsigned CNT_W bits. It never wraps; it saturates.

## Timing
- Reset values: `period`=0, `period_valid`=0, `timeout`=0, `lost`=0, state IDLE, `cnt`=0.
- Reset is asynchronous in both assertion and deassertion. Reset mid-measurement discards the partial count.
- Latency: `period_valid` and `period` are registered. They are visible on the cycle after the strobe is sampled.
- `timeout` is visible on the cycle after the saturating cycle. `lost` rises on the same cycle as `timeout`.
- `strobe` is ignored in IDLE and during the cycle `en` falls.

## Configuration
- `STROBE_PERIOD_AVG_EN` defined:
  - Each measured period is accumulated in a CNT_W+2-bit sum.
  - After every 4th measurement, `period` := sum>>2 (truncated) and `period_valid` pulses. The sum then clears.
  - OVERFLOW, `en`=0 or reset clears the sum and the sub-count.
- Not defined: every measurement is output directly, as described in Operation. The averaging logic is absent.

## Structure
- Shared package `strobe_pkg`:
  - state enum `spm_state_t` (IDLE, ARMED, MEASURE, OVERFLOW);
  - `SPM_AVG_LOG2` = 2.
- Sub-module `spm_avg`, instantiated only under `STROBE_PERIOD_AVG_EN`:
  - inputs: sample and valid;
  - outputs: mean and valid;
  - handles clear on OVERFLOW, `en`=0 and reset.

## Test plan
- `en`=1, strobes every 20 cycles (from a DIV=20 divider) -> first strobe gives no valid; each later strobe gives `period`=20 with one `period_valid` pulse, one cycle after the strobe.
- Strobes on consecutive cycles -> `period`=1 with `period_valid` high for two consecutive cycles.
- CNT_W=4, no strobe after arming -> 15 cycles after the first strobe, `timeout` pulses once and `lost`=1. The next strobe clears `lost` with no valid; the strobe after that reports its true spacing.
- CNT_W=4, second strobe exactly at saturation -> `period`=15, no `timeout`.
- `en` dropped mid-period, then raised -> no pulses while low; first strobe after re-enable only arms; `period` retains its old value throughout.
- `STROBE_PERIOD_AVG_EN` build, periods 20, 21, 22, 23 -> a single `period_valid` with `period`=21 (86>>2).
